// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the apb_top bridge.
// Define ARB_TIMEOUT_EN to abort transfers that see no pready for TIMEOUT_CYCLES.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        ptransfer,
    output logic        swrite,
    output logic [31:0] SADDR,
    output logic [31:0] SWDATA,
    input  logic        pready,
    input  logic [31:0] f_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last;
    logic       r_owner;
    logic       w_any;
    logic       w_winner;
    logic       w_grant;
    logic       w_finish;
    logic       w_timeout;

    // Contention goes to whoever was not served last; a lone request always wins.
    assign w_any    = req0 | req1;
    assign w_winner = (req0 & req1) ? ~r_last : req1;
    assign w_grant  = (r_state == IDLE) && w_any;
    assign w_finish = (r_state == XFER) && (pready || w_timeout);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Counter is about to reach TIMEOUT_CYCLES; a simultaneous pready takes priority.
    assign w_timeout = (r_state == XFER) && !pready
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != XFER) begin
                r_cnt <= '0;
            end else if (!pready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_err <= w_timeout;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^32'(TIMEOUT_CYCLES);
    assign w_timeout    = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = XFER;
            XFER:    if (pready || w_timeout) w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus fields are loaded once at grant and frozen until the next grant.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            ptransfer <= 1'b0;
            swrite    <= 1'b0;
            SADDR     <= '0;
            SWDATA    <= '0;
            rdata     <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            busy      <= 1'b0;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= (w_next != IDLE);
            if (w_grant) begin
                ptransfer <= 1'b1;
                swrite    <= w_winner ? wr1    : wr0;
                SADDR     <= w_winner ? addr1  : addr0;
                SWDATA    <= w_winner ? wdata1 : wdata0;
                r_owner   <= w_winner;
                r_last    <= w_winner;
            end
            if (w_finish) begin
                ptransfer <= 1'b0;
                done0     <= ~r_owner;
                done1     <= r_owner;
                if (w_timeout) begin
                    rdata <= '0;
                end else if (!swrite) begin
                    rdata <= f_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed sequences, a vector table
// and a randomized two-master run against a transaction-level reference model.
module tb_apb_req_arbiter;

    logic        pclk;
    logic        preset;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err, busy, ptransfer, swrite;
    logic [31:0] rdata, SADDR, SWDATA;
    logic        pready;
    logic [31:0] f_data;

    apb_req_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .preset(preset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
        .ptransfer(ptransfer), .swrite(swrite), .SADDR(SADDR), .SWDATA(SWDATA),
        .pready(pready), .f_data(f_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Simple slave memory standing in for apb_top (16 words).
    logic [31:0] mem [16];
    logic [31:0] m_rdata;

    task automatic slave_ack(input logic is_wr, input logic [31:0] a, input logic [31:0] d);
        pready = 1'b1;
        f_data = mem[a[3:0]];
        if (is_wr) mem[a[3:0]] = d;
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          dly;
        logic        own;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    // Random-phase model state.
    logic        rq_act [2];
    logic        rq_wr [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wd [2];
    int          cool [2];
    logic        d_req [2];
    logic        d_pready;
    int          ph;
    logic        own;
    logic        m_last;
    logic [31:0] m_fdata;
    int          wait_n;
    int          g_cnt [2];
    int          d_cnt [2];

    task automatic drive_reqs();
        req0 = rq_act[0]; wr0 = rq_wr[0]; addr0 = rq_addr[0]; wdata0 = rq_wd[0];
        req1 = rq_act[1]; wr1 = rq_wr[1]; addr1 = rq_addr[1]; wdata1 = rq_wd[1];
    endtask

    // One cycle of the random run: check what the last edge produced, then drive.
    task automatic rand_step(input bit allow_new);
        logic win;
        bit   fin;
        fin = 1'b0;
        tick();
        if (done0) d_cnt[0]++;
        if (done1) d_cnt[1]++;
        case (ph)
            0: begin
                chk1("rnd_idle_done", done0 | done1, 1'b0);
                if (d_req[0] | d_req[1]) begin
                    win    = (d_req[0] & d_req[1]) ? ~m_last : d_req[1];
                    m_last = win;
                    own    = win;
                    ph     = 1;
                    wait_n = 0;
                    g_cnt[win]++;
                end else begin
                    chk1("rnd_idle_pt", ptransfer, 1'b0);
                    chk1("rnd_idle_busy", busy, 1'b0);
                end
            end
            1: begin
                if (d_pready) begin
                    chk1("rnd_done_pt", ptransfer, 1'b0);
                    chk1("rnd_done0", done0, ~own);
                    chk1("rnd_done1", done1, own);
                    chk1("rnd_done_err", err, 1'b0);
                    chk1("rnd_done_busy", busy, 1'b1);
                    if (!rq_wr[own]) m_rdata = m_fdata;
                    chk32("rnd_rdata", rdata, m_rdata);
                    ph  = 2;
                    fin = 1'b1;
                end else begin
                    chk1("rnd_xfer_done", done0 | done1, 1'b0);
                end
            end
            default: begin
                chk1("rnd_gap_done", done0 | done1, 1'b0);
                chk1("rnd_gap_pt", ptransfer, 1'b0);
                chk1("rnd_gap_busy", busy, 1'b0);
                ph = 0;
            end
        endcase
        if (ph == 1) begin
            chk1("rnd_xfer_pt", ptransfer, 1'b1);
            chk1("rnd_xfer_busy", busy, 1'b1);
            chk32("rnd_saddr", SADDR, rq_addr[own]);
            chk1("rnd_swrite", swrite, rq_wr[own]);
            if (rq_wr[own]) chk32("rnd_swdata", SWDATA, rq_wd[own]);
        end
        for (int i = 0; i < 2; i++) begin
            if (fin && (int'(own) == i)) begin
                rq_act[i] = 1'b0;
                cool[i]   = int'($urandom_range(0, 2));
            end else if (!rq_act[i] && allow_new) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if ($urandom_range(0, 3) != 0) begin
                    rq_act[i]  = 1'b1;
                    rq_wr[i]   = 1'($urandom_range(0, 1));
                    rq_addr[i] = 32'($urandom_range(0, 15));
                    rq_wd[i]   = $urandom;
                end
            end
        end
        drive_reqs();
        if (ph == 1 && (wait_n >= 2 || $urandom_range(0, 2) == 0)) begin
            m_fdata = mem[rq_addr[own][3:0]];
            slave_ack(rq_wr[own], rq_addr[own], rq_wd[own]);
        end else begin
            if (ph == 1) wait_n++;
            pready = 1'b0;
            f_data = $urandom;
        end
        d_req[0] = rq_act[0];
        d_req[1] = rq_act[1];
        d_pready = pready;
    endtask

    initial begin
        logic exp_own;
        logic [31:0] exp_a;
        preset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pready = 1'b0; f_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_rdata = '0;

        // Reset held with both masters requesting: everything stays at zero.
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'hA; addr1 = 32'h8;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("rst_ptransfer", ptransfer, 1'b0);
            chk1("rst_swrite", swrite, 1'b0);
            chk32("rst_saddr", SADDR, 32'h0);
            chk32("rst_swdata", SWDATA, 32'h0);
            chk32("rst_rdata", rdata, 32'h0);
            chk1("rst_done0", done0, 1'b0);
            chk1("rst_done1", done1, 1'b0);
            chk1("rst_err", err, 1'b0);
            chk1("rst_busy", busy, 1'b0);
        end
        preset = 1'b1;

        // Continuous contention: grants alternate starting with master 0.
        mem[4'hA] = 32'hAAAA_0001;
        mem[4'h8] = 32'h8888_0002;
        for (int k = 0; k < 4; k++) begin
            exp_own = 1'((k % 2) != 0);
            exp_a   = exp_own ? 32'h8 : 32'hA;
            tick();
            chk1("cont_pt_hi", ptransfer, 1'b1);
            chk32("cont_saddr", SADDR, exp_a);
            chk1("cont_busy", busy, 1'b1);
            slave_ack(1'b0, exp_a, 32'h0);
            tick();
            pready = 1'b0;
            chk1("cont_pt_lo", ptransfer, 1'b0);
            chk1("cont_done0", done0, ~exp_own);
            chk1("cont_done1", done1, exp_own);
            chk32("cont_rdata", rdata, mem[exp_a[3:0]]);
            tick();
            chk1("cont_gap_pt", ptransfer, 1'b0);
            chk1("cont_gap_done", done0 | done1, 1'b0);
            chk1("cont_gap_busy", busy, 1'b0);
        end
        m_rdata = mem[4'h8];
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Reset in the middle of a transfer: no completion is reported.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h7; wdata0 = 32'h7777;
        tick();
        chk1("mid_pt_hi", ptransfer, 1'b1);
        preset = 1'b0;
        tick();
        chk1("mid_rst_pt", ptransfer, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done0 | done1, 1'b0);
        chk32("mid_rst_saddr", SADDR, 32'h0);
        preset = 1'b1; req0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("mid_after_done", done0 | done1, 1'b0);
            chk1("mid_after_pt", ptransfer, 1'b0);
        end
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_rdata = '0;

        // Vector table: {r0,r1,w0,w1,a0,a1,d0,d1,pready delay,owner,rdata}.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234, 32'h0, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h3, 32'h0, 32'h2234, 1, 1'b1, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3, 32'h0, 32'hDEAD, 0, 1'b1, 32'h2234};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h5, 32'h0, 32'h55, 2, 1'b0, 32'h1234};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h5, 32'h0, 32'h55, 0, 1'b1, 32'h1234};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0, 3, 1'b0, 32'h55};
        for (int v = 0; v < 6; v++) begin
            req0 = tbl[v].r0; wr0 = tbl[v].w0; addr0 = tbl[v].a0; wdata0 = tbl[v].d0;
            req1 = tbl[v].r1; wr1 = tbl[v].w1; addr1 = tbl[v].a1; wdata1 = tbl[v].d1;
            tick();
            chk1("vec_pt_hi", ptransfer, 1'b1);
            chk32("vec_saddr", SADDR, tbl[v].own ? tbl[v].a1 : tbl[v].a0);
            chk1("vec_swrite", swrite, tbl[v].own ? tbl[v].w1 : tbl[v].w0);
            if (tbl[v].own ? tbl[v].w1 : tbl[v].w0)
                chk32("vec_swdata", SWDATA, tbl[v].own ? tbl[v].d1 : tbl[v].d0);
            for (int k = 0; k < tbl[v].dly; k++) begin
                f_data = $urandom;
                tick();
                chk1("vec_wait_pt", ptransfer, 1'b1);
                chk1("vec_wait_done", done0 | done1, 1'b0);
            end
            slave_ack(swrite, SADDR, SWDATA);
            tick();
            pready = 1'b0;
            chk1("vec_done0", done0, ~tbl[v].own);
            chk1("vec_done1", done1, tbl[v].own);
            chk1("vec_pt_lo", ptransfer, 1'b0);
            chk1("vec_err", err, 1'b0);
            chk32("vec_rdata", rdata, tbl[v].exp_rdata);
            req0 = 1'b0; req1 = 1'b0;
            tick();
            chk1("vec_gap_done", done0 | done1, 1'b0);
            chk1("vec_gap_busy", busy, 1'b0);
            m_rdata = tbl[v].exp_rdata;
        end

`ifdef ARB_TIMEOUT_EN
        // No pready at all: abort after 4 XFER cycles with err and zero data.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h2; pready = 1'b0;
        tick();
        chk1("to_pt_hi", ptransfer, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("to_wait_done", done0, 1'b0);
        end
        tick();
        chk1("to_done0", done0, 1'b1);
        chk1("to_err", err, 1'b1);
        chk32("to_rdata", rdata, 32'h0);
        chk1("to_pt_lo", ptransfer, 1'b0);
        req0 = 1'b0;
        tick();
        chk1("to_idle_busy", busy, 1'b0);
        // pready on the timeout edge is a normal completion.
        mem[2] = 32'hCAFE;
        req0 = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        slave_ack(1'b0, 32'h2, 32'h0);
        tick();
        pready = 1'b0;
        chk1("to_race_done0", done0, 1'b1);
        chk1("to_race_err", err, 1'b0);
        chk32("to_race_rdata", rdata, 32'hCAFE);
        req0 = 1'b0;
        tick();
        m_rdata = 32'hCAFE;
`endif

        // Randomized two-master traffic against the reference model.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        m_last = 1'b0;
        ph = 0; own = 1'b0; wait_n = 0; m_fdata = '0;
        for (int i = 0; i < 2; i++) begin
            rq_act[i] = 1'b0; rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_wd[i] = '0;
            cool[i] = 0; d_req[i] = 1'b0; g_cnt[i] = 0; d_cnt[i] = 0;
        end
        d_pready = 1'b0;
        pready = 1'b0;
        drive_reqs();
        for (int c = 0; c < 3000; c++) rand_step(1'b1);
        for (int c = 0; c < 40; c++) begin
            if (ph == 0 && !rq_act[0] && !rq_act[1]) break;
            rand_step(1'b0);
        end
        chk1("rnd_drained", (ph == 0 && !rq_act[0] && !rq_act[1]), 1'b1);
        chk32("rnd_cnt0", 32'(d_cnt[0]), 32'(g_cnt[0]));
        chk32("rnd_cnt1", 32'(d_cnt[1]), 32'(g_cnt[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester round-robin arbiter and sequencer in front of the `apb_top` bridge. It accepts transfer requests from two independent masters and serialises them onto the bridge's `ptransfer`/`swrite`/`SADDR`/`SWDATA` inputs. It holds each transfer until `pready`, then returns the read data (`f_data`) and a one-cycle completion pulse to the granted requester.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles in XFER without `pready` before abort; only used with `ARB_TIMEOUT_EN`.

Ports:
- `pclk` in 1: single clock; all logic on rising edge.
- `preset` in 1: reset, synchronous, active-low.
- `req0`, `req1` in 1: transfer request. Level signal, held high until the matching done.
- `wr0`, `wr1` in 1: 1 = write, 0 = read. Stable while req is high.
- `addr0`, `addr1` in 32: target address.
- `wdata0`, `wdata1` in 32: write data; ignored for reads.
- `done0`, `done1` out 1: one-cycle completion pulse to the owning requester.
- `rdata` out 32: read data, valid in the done cycle.
- `err` out 1: timeout abort flag, valid in the done cycle.
- `busy` out 1: high in any state other than IDLE.
- `ptransfer` out 1: to `apb_top`.
- `swrite` out 1: to `apb_top`.
- `SADDR` out 32: to `apb_top`.
- `SWDATA` out 32: to `apb_top`.
- `pready` in 1: from `apb_top`.
- `f_data` in 32: from `apb_top`.

## Operation
- FSM has three states: IDLE, XFER, GAP.
- **IDLE**
  - If any req is high: pick a winner, register its `wr`/`addr`/`wdata` into `swrite`/`SADDR`/`SWDATA`, set `ptransfer`=1, record the owner, go to XFER.
  - Otherwise stay in IDLE.
- **Round-robin rule**
  - `last` register resets to 1, so `req0` wins first.
  - On simultaneous requests, the requester that is not `last` wins.
  - A single request always wins.
  - `last` updates on every grant.
- **XFER**
  - `ptransfer`, `swrite`, `SADDR`, `SWDATA` held constant.
  - Bus fields are frozen for the whole transfer; requester inputs are not re-sampled.
  - When `pready` is sampled 1:
    - `ptransfer` goes to 0.
    - `rdata` captures `f_data` on reads; unchanged on writes.
    - `err` goes to 0.
    - Owner's done is asserted for the next cycle.
    - Go to GAP.
- **GAP**
  - Exactly one cycle: `ptransfer`=0, done high for the owner, then go to IDLE.
  - Guarantees `apb_top` sees `ptransfer` low between transfers.
- **Requester duties**
  - Deassert req on the edge that samples done; otherwise it is re-arbitrated in the next IDLE cycle.
  - Dropping req during XFER does not abort the transfer; done still pulses.
- **Reset**
  - `preset`=0 at any edge, including mid-XFER, forces IDLE.
  - Reset values: `ptransfer`, `swrite`, `done0`, `done1`, `err`, `busy` = 0; `SADDR`, `SWDATA`, `rdata` = 0; `last`=1.
  - No done is issued for an interrupted transfer.

## Timing
- req high at edge N (IDLE) → `ptransfer`=1 from edge N+1.
- `pready` sampled 1 at edge M → `ptransfer`=0 and done=1 from M+1; IDLE from M+2.
- Earliest next grant is at edge M+2, so `ptransfer`=1 again from M+3.
- Minimum transfer with `pready` at the first XFER edge: 3 cycles from grant to back in IDLE.
- Back-to-back requests from both masters alternate: 0,1,0,1…
- `busy` is registered and tracks the state.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined**
  - A cycle counter clears on XFER entry and increments each XFER cycle with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES`: `ptransfer`=0, `rdata`=0, `err`=1, owner's done pulses, go to GAP.
  - `pready` on the same edge as the timeout wins: normal completion, `err`=0.
- **Undefined**
  - No counter; XFER waits indefinitely.
  - `err` tied to 0.

## Test plan
- **Reset:** hold `preset`=0 for 2 edges with both reqs high → all outputs 0, no done; release → `req0` is granted first.
- **Single write:** `req0`, `wr0`=1, `addr0`=0x4, `wdata0`=0x1234 → `SADDR`=0x4, `SWDATA`=0x1234, `swrite`=1, `ptransfer`=1 one cycle after req; `done0` one cycle after `pready`; `err`=0.
- **Read:** `req1`, `wr1`=0, `addr1`=0x3 after a write of 0x2234 to 0x3 → `rdata`=0x2234 in the `done1` cycle.
- **Contention:** both reqs held continuously (addr 0xA and 0x8) → grants alternate 0,1,0,1; `ptransfer` low for ≥1 cycle between transfers; no lost or duplicated done.
- **Reset mid-XFER:** `preset`=0 while `ptransfer`=1 → next cycle `ptransfer`=0, IDLE, no done pulse.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `pready` forced 0 → after 4 XFER cycles, `done0`=1, `err`=1, `rdata`=0, then IDLE.
